// File: rtl/fwrisc_rf_wr_sched.sv
// Write-port scheduler for the shared GPR/CSR register file: arbitrates trap-entry
// writes, exec writeback and background mirroring of the mcycle/minstret counters.
module fwrisc_rf_wr_sched #(
  parameter logic [5:0] CSR_MEPC        = 6'h31,
  parameter logic [5:0] CSR_MCAUSE      = 6'h32,
  parameter logic [5:0] CSR_MTVAL       = 6'h33,
  parameter logic [5:0] CSR_MCYCLE      = 6'h3C,
  parameter int         ENABLE_COUNTERS = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_wr_valid,
  output logic        ex_wr_ready,
  input  logic [5:0]  ex_wr_addr,
  input  logic [31:0] ex_wr_data,
  input  logic        trap_valid,
  output logic        trap_ready,
  input  logic [31:0] trap_epc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  output logic        trap_done,
  input  logic        instret,
  output logic        rf_wen,
  output logic [5:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [63:0] mcycle,
  output logic [63:0] minstret
);

  // MEPC is issued in the accept cycle itself, so only two follow-on states remain.
  typedef enum logic [1:0] {IDLE, T_CAUSE, T_MTVAL} state_t;

  state_t      state_reg, state_next;
  logic [31:0] cause_reg, tval_reg;
  logic [1:0]  ptr_reg;
  logic        rf_wen_reg, rf_wen_next;
  logic [5:0]  rf_waddr_reg, rf_waddr_next;
  logic [31:0] rf_wdata_reg, rf_wdata_next;
  logic        trap_done_reg, trap_done_next;
  logic        trap_accept, ex_accept, mirror_grant;
  logic [31:0] mirror_data;

  assign trap_ready   = (state_reg == IDLE);
  assign ex_wr_ready  = (state_reg == IDLE) && !trap_valid;
  assign trap_accept  = trap_ready && trap_valid;
  assign ex_accept    = ex_wr_ready && ex_wr_valid;
  assign mirror_grant = (ENABLE_COUNTERS != 0) && ex_wr_ready && !ex_wr_valid;

  always_comb begin
    mirror_data = mcycle[31:0];
    case (ptr_reg)
      2'd0: mirror_data = mcycle[31:0];
      2'd1: mirror_data = mcycle[63:32];
      2'd2: mirror_data = minstret[31:0];
      2'd3: mirror_data = minstret[63:32];
      default: mirror_data = mcycle[31:0];
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    rf_wen_next    = 1'b0;
    rf_waddr_next  = '0;
    rf_wdata_next  = '0;
    trap_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (trap_accept) begin
          rf_wen_next   = 1'b1;
          rf_waddr_next = CSR_MEPC;
          rf_wdata_next = trap_epc;
          state_next    = T_CAUSE;
        end else if (ex_accept) begin
          // x0 writes are consumed but never reach the register file
          rf_wen_next   = (ex_wr_addr != 6'd0);
          rf_waddr_next = ex_wr_addr;
          rf_wdata_next = ex_wr_data;
        end else if (mirror_grant) begin
          rf_wen_next   = 1'b1;
          rf_waddr_next = CSR_MCYCLE + {4'd0, ptr_reg};
          rf_wdata_next = mirror_data;
        end
      end
      T_CAUSE: begin
        rf_wen_next   = 1'b1;
        rf_waddr_next = CSR_MCAUSE;
        rf_wdata_next = cause_reg;
        state_next    = T_MTVAL;
      end
      T_MTVAL: begin
        rf_wen_next    = 1'b1;
        rf_waddr_next  = CSR_MTVAL;
        rf_wdata_next  = tval_reg;
        trap_done_next = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      cause_reg     <= '0;
      tval_reg      <= '0;
      ptr_reg       <= 2'd0;
      rf_wen_reg    <= 1'b0;
      rf_waddr_reg  <= '0;
      rf_wdata_reg  <= '0;
      trap_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rf_wen_reg    <= rf_wen_next;
      rf_waddr_reg  <= rf_waddr_next;
      rf_wdata_reg  <= rf_wdata_next;
      trap_done_reg <= trap_done_next;
      if (trap_accept) begin
        cause_reg <= trap_cause;
        tval_reg  <= trap_tval;
      end
      if (mirror_grant) ptr_reg <= ptr_reg + 2'd1;
    end
  end

  assign rf_wen    = rf_wen_reg;
  assign rf_waddr  = rf_waddr_reg;
  assign rf_wdata  = rf_wdata_reg;
  assign trap_done = trap_done_reg;

  generate
    if (ENABLE_COUNTERS != 0) begin : g_counters
      logic [63:0] mcycle_reg, mcycle_next;
      logic [63:0] minstret_reg, minstret_next;

      // A software write to a half replaces that cycle's increment entirely.
      always_comb begin
        mcycle_next   = mcycle_reg + 64'd1;
        minstret_next = minstret_reg + {63'd0, instret};
        if (ex_accept) begin
          case (ex_wr_addr)
            CSR_MCYCLE:         mcycle_next   = {mcycle_reg[63:32], ex_wr_data};
            CSR_MCYCLE + 6'd1:  mcycle_next   = {ex_wr_data, mcycle_reg[31:0]};
            CSR_MCYCLE + 6'd2:  minstret_next = {minstret_reg[63:32], ex_wr_data};
            CSR_MCYCLE + 6'd3:  minstret_next = {ex_wr_data, minstret_reg[31:0]};
            default: ;
          endcase
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          mcycle_reg   <= '0;
          minstret_reg <= '0;
        end else begin
          mcycle_reg   <= mcycle_next;
          minstret_reg <= minstret_next;
        end
      end

      assign mcycle   = mcycle_reg;
      assign minstret = minstret_reg;
    end else begin : g_no_counters
      assign mcycle   = '0;
      assign minstret = '0;
    end
  endgenerate

endmodule

// File: tb/tb_fwrisc_rf_wr_sched.sv
// Bench for fwrisc_rf_wr_sched: stimulus table plus a write scoreboard fed by a
// cycle-level reference of the arbitration rules and counters.
module tb_fwrisc_rf_wr_sched;

  localparam logic [5:0] A_MEPC = 6'h31, A_MCAUSE = 6'h32, A_MTVAL = 6'h33;
  localparam logic [5:0] A_MCYC = 6'h3C, A_MCYCH = 6'h3D, A_MINS = 6'h3E, A_MINSH = 6'h3F;

  logic        clock, reset;
  logic        ex_wr_valid, ex_wr_ready;
  logic [5:0]  ex_wr_addr;
  logic [31:0] ex_wr_data;
  logic        trap_valid, trap_ready, trap_done;
  logic [31:0] trap_epc, trap_cause, trap_tval;
  logic        instret;
  logic        rf_wen;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [63:0] mcycle, minstret;

  fwrisc_rf_wr_sched dut (
    .clock(clock), .reset(reset),
    .ex_wr_valid(ex_wr_valid), .ex_wr_ready(ex_wr_ready),
    .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
    .trap_valid(trap_valid), .trap_ready(trap_ready),
    .trap_epc(trap_epc), .trap_cause(trap_cause), .trap_tval(trap_tval),
    .trap_done(trap_done), .instret(instret),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mcycle(mcycle), .minstret(minstret)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        rst;
    logic        exv;
    logic [5:0]  exa;
    logic [31:0] exd;
    logic        trv;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [31:0] tval;
    logic        ir;
    logic        exp_exr;
    logic        exp_trr;
  } vec_t;

  typedef struct packed {
    logic        wen;
    logic [5:0]  addr;
    logic [31:0] data;
    logic        done;
  } wr_t;

  vec_t tbl[$];
  wr_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   vec_no = 0;

  // reference state
  int          m_trap_left;
  logic [31:0] m_cause, m_tval;
  int          m_ptr;
  logic [63:0] m_cyc, m_ins;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic exv, input logic [5:0] exa, input logic [31:0] exd,
                     input logic trv, input logic [31:0] epc, input logic [31:0] cause,
                     input logic [31:0] tval, input logic ir, input logic exr, input logic trr);
    vec_t v;
    v = '{rst, exv, exa, exd, trv, epc, cause, tval, ir, exr, trr};
    tbl.push_back(v);
  endtask

  task automatic idle(input int n, input logic ir);
    for (int i = 0; i < n; i++) add(0, 0, 6'd0, 32'd0, 0, 32'd0, 32'd0, 32'd0, ir, 1, 1);
  endtask

  task automatic model_reset();
    m_trap_left = 0;
    m_cause = '0;
    m_tval = '0;
    m_ptr = 0;
    m_cyc = '0;
    m_ins = '0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  // Decide this cycle's grant from the priority rules, then advance the counters.
  task automatic model_step(input vec_t v);
    wr_t         w;
    logic [63:0] nc, ni;
    w  = '0;
    nc = m_cyc + 64'd1;
    ni = m_ins + (v.ir ? 64'd1 : 64'd0);
    if (m_trap_left == 2) begin
      w = '{1'b1, A_MCAUSE, m_cause, 1'b0};
      m_trap_left = 1;
    end else if (m_trap_left == 1) begin
      w = '{1'b1, A_MTVAL, m_tval, 1'b1};
      m_trap_left = 0;
    end else if (v.trv) begin
      w = '{1'b1, A_MEPC, v.epc, 1'b0};
      m_cause = v.cause;
      m_tval = v.tval;
      m_trap_left = 2;
    end else if (v.exv) begin
      w = '{(v.exa != 6'd0), v.exa, v.exd, 1'b0};
      if (v.exa == A_MCYC)  nc = {m_cyc[63:32], v.exd};
      if (v.exa == A_MCYCH) nc = {v.exd, m_cyc[31:0]};
      if (v.exa == A_MINS)  ni = {m_ins[63:32], v.exd};
      if (v.exa == A_MINSH) ni = {v.exd, m_ins[31:0]};
    end else begin
      case (m_ptr)
        0: w = '{1'b1, A_MCYC,  m_cyc[31:0],  1'b0};
        1: w = '{1'b1, A_MCYCH, m_cyc[63:32], 1'b0};
        2: w = '{1'b1, A_MINS,  m_ins[31:0],  1'b0};
        default: w = '{1'b1, A_MINSH, m_ins[63:32], 1'b0};
      endcase
      m_ptr = (m_ptr + 1) % 4;
    end
    m_cyc = nc;
    m_ins = ni;
    exp_q.push_back(w);
  endtask

  // Entered and left at posedge+1.
  task automatic apply(input vec_t v);
    wr_t e;
    reset       = v.rst;
    ex_wr_valid = v.exv;
    ex_wr_addr  = v.exa;
    ex_wr_data  = v.exd;
    trap_valid  = v.trv;
    trap_epc    = v.epc;
    trap_cause  = v.cause;
    trap_tval   = v.tval;
    instret     = v.ir;
    @(negedge clock);
    $display("vec %0d: rst=%b ex=%b %h/%h trap=%b ir=%b -> wen=%b %h/%h done=%b",
             vec_no, v.rst, v.exv, v.exa, v.exd, v.trv, v.ir, rf_wen, rf_waddr, rf_wdata, trap_done);
    vec_no++;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      check("rf_wen", {63'd0, rf_wen}, {63'd0, e.wen});
      if (e.wen) begin
        check("rf_waddr", {58'd0, rf_waddr}, {58'd0, e.addr});
        check("rf_wdata", {32'd0, rf_wdata}, {32'd0, e.data});
      end
      check("trap_done", {63'd0, trap_done}, {63'd0, e.done});
    end
    check("mcycle", mcycle, m_cyc);
    check("minstret", minstret, m_ins);
    check("ex_wr_ready", {63'd0, ex_wr_ready}, {63'd0, v.exp_exr});
    check("trap_ready", {63'd0, trap_ready}, {63'd0, v.exp_trr});
    if (v.rst) model_reset();
    else model_step(v);
    @(posedge clock);
    #1;
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    tbl.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ex_wr_valid = 0; ex_wr_addr = '0; ex_wr_data = '0;
    trap_valid = 0; trap_epc = '0; trap_cause = '0; trap_tval = '0;
    instret = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // idle after reset: mirror stream starts at MCYCLE with data 0
    idle(6, 0);
    // exec writes, including x0 which is swallowed
    add(0, 1, 6'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 1);
    idle(1, 0);
    add(0, 1, 6'd0, 32'h00001234, 0, 0, 0, 0, 0, 1, 1);
    idle(2, 1);
    // trap and exec together; operand changes after accept must be ignored
    add(0, 1, 6'd7, 32'h0000AAAA, 1, 32'h100, 32'hB, 32'h0, 0, 0, 1);
    add(0, 1, 6'd7, 32'h0000AAAA, 1, 32'hDEAD, 32'hEEEE, 32'hFFFF, 0, 0, 0);
    add(0, 1, 6'd7, 32'h0000AAAA, 0, 32'hDEAD, 32'hEEEE, 32'hFFFF, 0, 0, 0);
    add(0, 1, 6'd7, 32'h0000AAAA, 0, 0, 0, 0, 1, 1, 1);
    idle(1, 0);
    // software load of mcycle low then high, carry follows
    add(0, 1, A_MCYC, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1, 1);
    add(0, 1, A_MCYCH, 32'h0, 0, 0, 0, 0, 0, 1, 1);
    idle(1, 0);
    run_tbl();
    check("mcycle_carry", mcycle, 64'h0000_0001_0000_0000);

    // minstret load while instret pulses: load replaces the increment
    add(0, 1, A_MINS, 32'h00000010, 0, 0, 0, 0, 1, 1, 1);
    add(0, 1, A_MINSH, 32'h00000001, 0, 0, 0, 0, 1, 1, 1);
    idle(5, 1);
    // reset during the MTVAL grant cycle
    add(0, 0, 6'd0, 32'd0, 1, 32'h200, 32'h7, 32'h77, 0, 0, 1);
    idle(1, 0);
    tbl[tbl.size()-1].exp_exr = 0;
    tbl[tbl.size()-1].exp_trr = 0;
    add(1, 0, 6'd0, 32'd0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 0);
    run_tbl();
    check("post_reset_mirror_addr", {58'd0, rf_waddr}, {58'd0, A_MCYC});
    check("post_reset_mirror_data", {32'd0, rf_wdata}, 64'd0);
    check("post_reset_no_done", {63'd0, trap_done}, 64'd0);

    // three retirements under exec ownership, then MINSTRET mirror carries 3
    do_reset();
    for (int i = 1; i <= 3; i++) add(0, 1, 6'd1, i, 0, 0, 0, 0, 1, 1, 1);
    idle(3, 0);
    run_tbl();
    check("minstret_mirror_wen", {63'd0, rf_wen}, 64'd1);
    check("minstret_mirror_addr", {58'd0, rf_waddr}, {58'd0, A_MINS});
    check("minstret_mirror_data", {32'd0, rf_wdata}, 64'd3);

    // a little random traffic
    for (int i = 0; i < 40; i++) begin
      logic trv, exv;
      logic [5:0] a;
      trv = ($urandom_range(0, 7) == 0);
      exv = ($urandom_range(0, 2) == 0);
      a = 6'($urandom_range(0, 63));
      add(0, exv, a, $urandom, trv, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
          !trv, 1);
      run_tbl_guarded();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Random vectors need the ready expectation from trap-sequence progress.
  task automatic run_tbl_guarded();
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      if (m_trap_left != 0) begin
        v.exp_exr = 0;
        v.exp_trr = 0;
      end
      apply(v);
    end
    tbl.delete();
  endtask

endmodule
